// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: FSM state encoding,
// MIPS ExcCode constants, default handler/reset PCs and PC step helpers.
package cpu_defs;

    // Sequencer states; one event occupies IDLE (sample) + two more cycles.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } seq_state_e;

    // Number of hardware interrupt lines seen by SR.IM.
    localparam int INT_LINES = 6;

    // ExcCode values recorded into CP0 Cause.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Default PCs; the top module exposes these as overridable parameters.
    localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_3000;

    // Next sequential PC, wrapping at 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Previous sequential PC (branch owning a delay slot), wrapping at 0.
    function automatic logic [31:0] pc_prev(input logic [31:0] pc);
        return pc - 32'd4;
    endfunction

endpackage

// File: rtl/exc_sequencer_int_pending.sv
// Masked hardware-interrupt reduction: an interrupt is pending when any
// enabled line is high, interrupts are globally enabled and the core is
// not already at exception level.
module int_pending
    import cpu_defs::*;
(
    input  logic [INT_LINES-1:0] hw_int_i,
    input  logic [INT_LINES-1:0] sr_im_i,
    input  logic                 sr_ie_i,
    input  logic                 sr_exl_i,
    output logic                 int_req_o
);

    // Pure combinational reduction; no state.
    assign int_req_o = (|(hw_int_i & sr_im_i)) & sr_ie_i & ~sr_exl_i;

endmodule

// File: rtl/exc_sequencer.sv
// Exception / interrupt / eret sequencer around the CP0 exception bridge.
// In IDLE it samples the M stage and the masked interrupts, picks one event
// (interrupt > exception > eret), then runs a fixed sequence:
//   ENTER (CP0 record pulse + flush) or RET (EXL clear pulse + flush),
//   then REDIR (PC redirect + flush), then back to IDLE.
// Optional feature: define EXC_BD_EN to record delay-slot entries with
// EPC = branch PC and BD = 1; without it m_bd is ignored and cp0_bd is 0.
module exc_sequencer
    import cpu_defs::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        m_exc_valid,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_bubble,
    input  logic        m_eret,
    input  logic [5:0]  hw_int,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [31:0] epc_in,
    output logic        cp0_we_exc,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        cp0_exl_clr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    seq_state_e  state_q;
    logic [31:0] last_pc_q;     // PC of the last valid M-stage instruction
    logic [31:0] target_q;      // redirect target captured at the sample edge
    logic        cp0_we_exc_q;
    logic [4:0]  cp0_exc_code_q;
    logic [31:0] cp0_epc_q;
    logic        cp0_bd_q;
    logic        cp0_exl_clr_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    // Event decode
    logic        int_req;
    logic        exc_req;
    logic        eret_req;
    logic        enter_req;

    // Values captured for the winning event
    logic [4:0]  ev_code_d;
    logic [31:0] ev_epc_d;
    logic        ev_bd_d;
    logic [31:0] ev_target_d;

    int_pending u_int_pending (
        .hw_int_i  (hw_int),
        .sr_im_i   (sr_im),
        .sr_ie_i   (sr_ie),
        .sr_exl_i  (sr_exl),
        .int_req_o (int_req)
    );

    assign exc_req   = m_exc_valid & ~m_bubble;
    assign eret_req  = m_eret & ~m_bubble & ~m_exc_valid;
    assign enter_req = int_req | exc_req;

`ifndef EXC_BD_EN
    // Delay-slot flag has no effect in this build.
    logic m_bd_unused;
    assign m_bd_unused = m_bd;
`endif

    // Build the code/EPC/BD/target that would be recorded if an event is
    // taken this cycle. An interrupt on a bubble resumes after the last
    // valid instruction; otherwise the M-stage instruction is re-executed.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        ev_code_d   = EXC_INT;
        ev_epc_d    = m_pc;
        ev_bd_d     = 1'b0;
        ev_target_d = HANDLER_ADDR;

        if (m_bubble) begin
            ev_epc_d = pc_next(last_pc_q);
        end
`ifdef EXC_BD_EN
        else if (m_bd) begin
            ev_epc_d = pc_prev(m_pc);
            ev_bd_d  = 1'b1;
        end
`endif

        if (!int_req) begin
            ev_code_d = m_exc_code;
        end
        if (!int_req && !exc_req) begin
            ev_target_d = epc_in;
        end
    end

    // Sequencer FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            last_pc_q        <= pc_prev(RESET_PC);
            target_q         <= '0;
            cp0_we_exc_q     <= 1'b0;
            cp0_exc_code_q   <= '0;
            cp0_epc_q        <= '0;
            cp0_bd_q         <= 1'b0;
            cp0_exl_clr_q    <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees
            // the pre-edge values; the later case branches override these
            // defaults without creating ordering hazards.
            cp0_we_exc_q     <= 1'b0;
            cp0_exc_code_q   <= '0;
            cp0_epc_q        <= '0;
            cp0_bd_q         <= 1'b0;
            cp0_exl_clr_q    <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (!m_bubble) begin
                        last_pc_q <= m_pc;
                    end
                    if (enter_req) begin
                        state_q        <= ST_ENTER;
                        target_q       <= ev_target_d;
                        cp0_we_exc_q   <= 1'b1;
                        cp0_exc_code_q <= ev_code_d;
                        cp0_epc_q      <= ev_epc_d;
                        cp0_bd_q       <= ev_bd_d;
                        flush_q        <= 1'b1;
                    end else if (eret_req) begin
                        state_q       <= ST_RET;
                        target_q      <= ev_target_d;
                        cp0_exl_clr_q <= 1'b1;
                        flush_q       <= 1'b1;
                    end
                end

                ST_ENTER, ST_RET: begin
                    state_q          <= ST_REDIR;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target_q;
                    flush_q          <= 1'b1;
                end

                ST_REDIR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cp0_we_exc     = cp0_we_exc_q;
    assign cp0_exc_code   = cp0_exc_code_q;
    assign cp0_epc        = cp0_epc_q;
`ifdef EXC_BD_EN
    assign cp0_bd         = cp0_bd_q;
`else
    logic cp0_bd_q_unused;
    assign cp0_bd_q_unused = cp0_bd_q;
    assign cp0_bd         = 1'b0;
`endif
    assign cp0_exl_clr    = cp0_exl_clr_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer. Inputs change and outputs are checked
// on the falling edge, half a cycle away from the sampling edge.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_exc_valid;
    logic [4:0]  m_exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_bubble;
    logic        m_eret;
    logic [5:0]  hw_int;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic [31:0] epc_in;
    logic        cp0_we_exc;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_epc;
    logic        cp0_bd;
    logic        cp0_exl_clr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] HANDLER = 32'h0000_4180;

    exc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .m_exc_valid    (m_exc_valid),
        .m_exc_code     (m_exc_code),
        .m_pc           (m_pc),
        .m_bd           (m_bd),
        .m_bubble       (m_bubble),
        .m_eret         (m_eret),
        .hw_int         (hw_int),
        .sr_im          (sr_im),
        .sr_ie          (sr_ie),
        .sr_exl         (sr_exl),
        .epc_in         (epc_in),
        .cp0_we_exc     (cp0_we_exc),
        .cp0_exc_code   (cp0_exc_code),
        .cp0_epc        (cp0_epc),
        .cp0_bd         (cp0_bd),
        .cp0_exl_clr    (cp0_exl_clr),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Quiet pipeline: bubble in M, no requests, interrupts disabled.
    task automatic idle_inputs();
        m_exc_valid = 1'b0;
        m_exc_code  = 5'd0;
        m_pc        = 32'd0;
        m_bd        = 1'b0;
        m_bubble    = 1'b1;
        m_eret      = 1'b0;
        hw_int      = 6'd0;
        sr_im       = 6'd0;
        sr_ie       = 1'b0;
        sr_exl      = 1'b0;
        epc_in      = 32'd0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"},    {31'd0, cp0_we_exc},     32'd0);
        check({tag, "_clr"},   {31'd0, cp0_exl_clr},    32'd0);
        check({tag, "_flush"}, {31'd0, flush},          32'd0);
        check({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
        check({tag, "_rpc"},   redirect_pc,             32'd0);
        check({tag, "_epc"},   cp0_epc,                 32'd0);
        check({tag, "_code"},  {27'd0, cp0_exc_code},   32'd0);
        check({tag, "_bd"},    {31'd0, cp0_bd},         32'd0);
    endtask

    // Called in the ENTER cycle: checks ENTER, releases inputs, then checks
    // REDIR and the return to IDLE.
    task automatic expect_enter(input string tag, input logic [4:0] code,
                                input logic [31:0] epc, input logic bd,
                                input logic [31:0] target);
        check({tag, "_we"},    {31'd0, cp0_we_exc},   32'd1);
        check({tag, "_flush"}, {31'd0, flush},        32'd1);
        check({tag, "_code"},  {27'd0, cp0_exc_code}, {27'd0, code});
        check({tag, "_epc"},   cp0_epc,               epc);
        check({tag, "_bd"},    {31'd0, cp0_bd},       {31'd0, bd});
        check({tag, "_clr"},   {31'd0, cp0_exl_clr},  32'd0);
        idle_inputs();
        @(negedge clk);
        check({tag, "_redir_rv"},    {31'd0, redirect_valid}, 32'd1);
        check({tag, "_redir_pc"},    redirect_pc,             target);
        check({tag, "_redir_flush"}, {31'd0, flush},          32'd1);
        check({tag, "_redir_we"},    {31'd0, cp0_we_exc},     32'd0);
        check({tag, "_redir_epc"},   cp0_epc,                 32'd0);
        @(negedge clk);
        check_quiet({tag, "_done"});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        // Interrupt on a bubble straight after reset: EPC = (RESET_PC-4)+4.
        hw_int = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1;
        @(negedge clk);
        expect_enter("int_first", 5'd0, 32'h0000_3000, 1'b0, HANDLER);

        // Overflow exception.
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd12; m_pc = 32'h0000_3010;
        @(negedge clk);
        expect_enter("ov", 5'd12, 32'h0000_3010, 1'b0, HANDLER);

        // Interrupt on a bubble after a valid instruction at 0x3020.
        m_bubble = 1'b0; m_pc = 32'h0000_3020;
        @(negedge clk);
        check_quiet("track");
        idle_inputs();
        hw_int = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1;
        @(negedge clk);
        expect_enter("int_bubble", 5'd0, 32'h0000_3024, 1'b0, HANDLER);

        // Masked by EXL: nothing happens, then an exception enters normally.
        hw_int = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1; sr_exl = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("masked");
        end
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd10; m_pc = 32'h0000_3030;
        @(negedge clk);
        expect_enter("ri_masked", 5'd10, 32'h0000_3030, 1'b0, HANDLER);

        // eret: target sampled at the request edge, later EPC writes ignored.
        m_bubble = 1'b0; m_eret = 1'b1; m_pc = 32'h0000_3038; epc_in = 32'h0000_3040;
        @(negedge clk);
        check("eret_clr",   {31'd0, cp0_exl_clr},    32'd1);
        check("eret_flush", {31'd0, flush},          32'd1);
        check("eret_we",    {31'd0, cp0_we_exc},     32'd0);
        check("eret_rv",    {31'd0, redirect_valid}, 32'd0);
        idle_inputs();
        epc_in = 32'h0000_5000;
        @(negedge clk);
        check("eret_redir_rv",    {31'd0, redirect_valid}, 32'd1);
        check("eret_redir_pc",    redirect_pc,             32'h0000_3040);
        check("eret_redir_flush", {31'd0, flush},          32'd1);
        check("eret_redir_clr",   {31'd0, cp0_exl_clr},    32'd0);
        @(negedge clk);
        check_quiet("eret_done");

        // Delay-slot exception.
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd4; m_pc = 32'h0000_3008; m_bd = 1'b1;
        @(negedge clk);
`ifdef EXC_BD_EN
        expect_enter("bd", 5'd4, 32'h0000_3004, 1'b1, HANDLER);
`else
        expect_enter("bd", 5'd4, 32'h0000_3008, 1'b0, HANDLER);
`endif

        // Interrupt and exception together: interrupt wins with code 0.
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd12; m_pc = 32'h0000_3050;
        hw_int = 6'b100000; sr_im = 6'b100000; sr_ie = 1'b1;
        @(negedge clk);
        expect_enter("int_vs_exc", 5'd0, 32'h0000_3050, 1'b0, HANDLER);

        // Interrupt and eret together: interrupt wins, EPC = eret PC.
        m_bubble = 1'b0; m_eret = 1'b1; m_pc = 32'h0000_3058; epc_in = 32'h0000_3100;
        hw_int = 6'b000001; sr_im = 6'b000001; sr_ie = 1'b1;
        @(negedge clk);
        expect_enter("int_vs_eret", 5'd0, 32'h0000_3058, 1'b0, HANDLER);

        // Wrap-around: last valid PC 0xFFFFFFFC, bubble interrupt -> EPC 0.
        m_bubble = 1'b0; m_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        idle_inputs();
        hw_int = 6'b000010; sr_im = 6'b000010; sr_ie = 1'b1;
        @(negedge clk);
        expect_enter("wrap", 5'd0, 32'h0000_0000, 1'b0, HANDLER);

        // Reset during ENTER: no REDIR follows.
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd5; m_pc = 32'h0000_3060;
        @(negedge clk);
        check("rst_enter_we", {31'd0, cp0_we_exc}, 32'd1);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rst_enter");
        reset = 1'b0;
        @(negedge clk);
        check_quiet("rst_no_redir");

        // Request held through ENTER/REDIR is taken again only from IDLE.
        m_bubble = 1'b0; m_exc_valid = 1'b1; m_exc_code = 5'd12; m_pc = 32'h0000_3070;
        @(negedge clk);
        check("hold_we1", {31'd0, cp0_we_exc}, 32'd1);
        @(negedge clk);
        check("hold_rv",  {31'd0, redirect_valid}, 32'd1);
        check("hold_we2", {31'd0, cp0_we_exc},     32'd0);
        @(negedge clk);
        check_quiet("hold_idle");
        @(negedge clk);
        expect_enter("hold_again", 5'd12, 32'h0000_3070, 1'b0, HANDLER);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
